// File: rtl/rotsq_sequencer.sv
// rtl/rotsq_sequencer.sv - rotating-square scheduler for the 4-digit seven-segment panel
module rotsq_sequencer #(
    parameter int STEP_DIV = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       sel,
    input  logic       step,
    input  logic       clr,
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic [2:0] pos,
    output logic       step_tick
);

    localparam int CW = $clog2(STEP_DIV);
    localparam logic [CW-1:0] TERM = CW'(STEP_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [2:0]      pos_nx;
    logic            advance;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            pos       <= 3'd0;
            step_tick <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            pos       <= pos_nx;
            step_tick <= advance;
        end
    end

    // Counter and pos freeze in the cycle en drops, even at terminal count.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        advance  = 1'b0;
        if (clr) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nx = '0;
                    if (en) state_nx = RUN;
                end
                RUN: begin
                    if (!en) begin
                        state_nx = PAUSE;
                    end else if (cnt == TERM) begin
                        cnt_nx  = '0;
                        advance = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                PAUSE: begin
                    if (en) state_nx = RUN;
                    else    advance  = step;
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end

        if (clr || state_nx == IDLE) pos_nx = 3'd0;
        else if (advance)            pos_nx = sel ? pos - 3'd1 : pos + 3'd1;
        else                         pos_nx = pos;
    end

    // Upper square walks digits 3..0, lower square walks back 0..3.
    always_comb begin
        an   = 4'b1111;
        sseg = 8'hFF;
        if (state == RUN || state == PAUSE) begin
            if (!pos[2]) begin
                an   = ~(4'b1000 >> pos[1:0]);
                sseg = 8'h9C;
            end else begin
                an   = ~(4'b0001 << pos[1:0]);
                sseg = 8'hA3;
            end
        end
    end

endmodule

// File: tb/tb_rotsq_sequencer.sv
// tb/tb_rotsq_sequencer.sv - self-checking bench for rotsq_sequencer
module tb_rotsq_sequencer;

    localparam int STEP_DIV = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       en    = 1'b0;
    logic       sel   = 1'b0;
    logic       step  = 1'b0;
    logic       clr   = 1'b0;
    logic [3:0] an;
    logic [7:0] sseg;
    logic [2:0] pos;
    logic       step_tick;

    int checks = 0;
    int errors = 0;

    typedef enum int {M_IDLE, M_RUN, M_PAUSE} mode_t;
    mode_t m_mode;
    int    m_pos;
    int    m_runs;
    bit    m_tick;

    rotsq_sequencer #(.STEP_DIV(STEP_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .sel       (sel),
        .step      (step),
        .clr       (clr),
        .an        (an),
        .sseg      (sseg),
        .pos       (pos),
        .step_tick (step_tick)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_pos  = 0;
        m_runs = 0;
        m_tick = 0;
    endtask

    // Position follows the number of running cycles since the last clear.
    task automatic model_edge();
        bit adv;
        adv = 0;
        if (clr) begin
            m_mode = M_IDLE;
            m_pos  = 0;
            m_runs = 0;
        end else begin
            case (m_mode)
                M_IDLE:  if (en) m_mode = M_RUN;
                M_RUN: begin
                    if (!en) m_mode = M_PAUSE;
                    else begin
                        m_runs++;
                        adv = (m_runs % STEP_DIV) == 0;
                    end
                end
                default: begin
                    if (en) m_mode = M_RUN;
                    else    adv = step;
                end
            endcase
        end
        if (adv) m_pos = (m_pos + (sel ? 7 : 1)) % 8;
        m_tick = adv;
    endtask

    function automatic logic [3:0] model_an();
        logic [3:0] e;
        int         digit;
        e = 4'hF;
        if (m_mode != M_IDLE) begin
            digit    = (m_pos < 4) ? 3 - m_pos : m_pos - 4;
            e[digit] = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [7:0] model_sseg();
        if (m_mode == M_IDLE) return 8'hFF;
        return (m_pos < 4) ? 8'h9C : 8'hA3;
    endfunction

    task automatic check_all(input string tag);
        expect_eq({tag, "_pos"},  32'(pos),       32'(m_pos));
        expect_eq({tag, "_tick"}, 32'(step_tick), 32'(m_tick));
        expect_eq({tag, "_an"},   32'(an),        32'(model_an()));
        expect_eq({tag, "_sseg"}, 32'(sseg),      32'(model_sseg()));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic run_until_pos(input string tag, input int target, output bit found);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            cycle(tag);
            if (m_pos == target) found = 1;
        end
    endtask

    initial begin
        int ticks;
        bit found;

        model_reset();
        #12;
        check_all("reset");
        reset = 1'b1;

        // Clockwise run from IDLE: one full revolution.
        en    = 1'b1;
        sel   = 1'b0;
        ticks = 0;
        cycle("t2_enter");
        expect_eq("t2_first_an", 32'(an), 32'h7);
        for (int i = 0; i < 32; i++) begin
            cycle("t2_run");
            if (step_tick) ticks++;
            if (m_pos == 4 && m_tick) begin
                expect_eq("t2_pos4_an",   32'(an),   32'hE);
                expect_eq("t2_pos4_sseg", 32'(sseg), 32'hA3);
            end
        end
        expect_eq("t2_ticks", ticks, 8);
        expect_eq("t2_wrap_pos", 32'(pos), 32'd0);

        // Counter-clockwise from 0 wraps to 7, then 6.
        sel = 1'b1;
        for (int i = 0; i < 8; i++) cycle("t3_ccw");
        expect_eq("t3_pos", 32'(pos), 32'd6);

        // Pause exactly in the terminal-count cycle at pos 2.
        sel   = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_pos == 2 && ((m_runs + 1) % STEP_DIV) == 0) found = 1;
            else cycle("t4_seek");
        end
        expect_eq("t4_reach", 32'(found), 32'd1);
        en = 1'b0;
        cycle("t4_pause");
        expect_eq("t4_held_pos",  32'(pos),       32'd2);
        expect_eq("t4_held_tick", 32'(step_tick), 32'd0);
        cycle("t4_hold");
        en = 1'b1;
        cycle("t4_resume");
        cycle("t4_first_run");
        expect_eq("t4_adv_pos", 32'(pos), 32'd3);

        // Single step from PAUSE at pos 7, then a step in RUN.
        run_until_pos("t5_seek", 7, found);
        expect_eq("t5_reach", 32'(found), 32'd1);
        en = 1'b0;
        cycle("t5_pause");
        step = 1'b1;
        cycle("t5_step");
        step = 1'b0;
        expect_eq("t5_step_pos",  32'(pos),       32'd0);
        expect_eq("t5_step_tick", 32'(step_tick), 32'd1);
        cycle("t5_after");
        en = 1'b1;
        cycle("t5_run");
        step = 1'b1;
        cycle("t5_run_step");
        step = 1'b0;
        cycle("t5_run_after");

        // Clear with en high while paused at pos 3.
        run_until_pos("t6_seek", 3, found);
        expect_eq("t6_reach", 32'(found), 32'd1);
        en = 1'b0;
        cycle("t6_pause");
        clr = 1'b1;
        en  = 1'b1;
        cycle("t6_clr");
        expect_eq("t6_clr_an",  32'(an),  32'hF);
        expect_eq("t6_clr_pos", 32'(pos), 32'd0);
        clr = 1'b0;
        cycle("t6_run");
        expect_eq("t6_run_an", 32'(an), 32'h7);

        // Asynchronous reset mid-run at pos 5.
        run_until_pos("t1_seek", 5, found);
        expect_eq("t1_reach", 32'(found), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("t1_async");
        expect_eq("t1_sseg", 32'(sseg), 32'hFF);
        #2;
        reset = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            en   = ($urandom % 4) != 0;
            if (($urandom % 8) == 0) sel = ~sel;
            step = ($urandom % 3) == 0;
            clr  = ($urandom % 50) == 0;
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
